// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface ex_stage_if;
    // ID/EX side
    logic [1:0]  wb_in;
    logic [2:0]  mem_in;
    logic [3:0]  ex_ctl;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sign_ext;
    logic [4:0]  rt;
    logic [4:0]  rd;

    // stall back to ID and EX/MEM side
    logic        ex_busy;
    logic [1:0]  wb_out;
    logic [2:0]  mem_out;
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rd2_out;
    logic [4:0]  write_reg;

    // upstream / environment view
    modport master (
        output wb_in, mem_in, ex_ctl, npc, rd1, rd2, sign_ext, rt, rd,
        input  ex_busy, wb_out, mem_out, branch_target, zero,
               alu_result, rd2_out, write_reg
    );

    // execute-stage view
    modport slave (
        input  wb_in, mem_in, ex_ctl, npc, rd1, rd2, sign_ext, rt, rd,
        output ex_busy, wb_out, mem_out, branch_target, zero,
               alu_result, rd2_out, write_reg
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select, iterative MULT,
// and the EX/MEM pipeline register.
module ex_stage #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int unsigned XLEN  = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  mul_a;
    logic [XLEN-1:0]  mul_b;
    logic [XLEN-1:0]  product;

    logic             reg_dst;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic [5:0]       funct;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  alu_c;
    logic             is_mult_c;

    logic             busy_c;
    logic             mul_start_c;
    logic             mul_step_c;
    logic             mul_finish_c;

    assign reg_dst = bus.ex_ctl[3];
    assign alu_op  = bus.ex_ctl[2:1];
    assign alu_src = bus.ex_ctl[0];
    assign funct   = bus.sign_ext[5:0];
    assign op_b    = alu_src ? bus.sign_ext : bus.rd2;

    assign is_mult_c = (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MULT);

    // Single-cycle ALU; mult and unknown functs produce 0 here.
    always_comb begin
        alu_c = '0;
        case (alu_op)
            ALUOP_ADD: alu_c = bus.rd1 + op_b;
            ALUOP_SUB: alu_c = bus.rd1 - op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_c = bus.rd1 + op_b;
                    FUNCT_SUB: alu_c = bus.rd1 - op_b;
                    FUNCT_AND: alu_c = bus.rd1 & op_b;
                    FUNCT_OR:  alu_c = bus.rd1 | op_b;
                    FUNCT_SLT: alu_c = ($signed(bus.rd1) < $signed(op_b)) ? XLEN'(1) : '0;
                    default:   alu_c = '0;
                endcase
            end
            default: alu_c = '0;
        endcase
    end

    // MULT FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MULT FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mult_c) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (count == CNT_W'(MUL_CYCLES - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The held mult is still on the inputs; it must not restart.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // MULT FSM outputs: stall request and datapath controls.
    always_comb begin
        busy_c       = 1'b0;
        mul_start_c  = 1'b0;
        mul_step_c   = 1'b0;
        mul_finish_c = 1'b0;
        case (state)
            IDLE: begin
                if (is_mult_c) begin
                    busy_c      = 1'b1;
                    mul_start_c = 1'b1;
                end
            end
            MUL: begin
                busy_c     = 1'b1;
                mul_step_c = 1'b1;
            end
            DONE: begin
                mul_finish_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    // Reset wins over a stall request in the same cycle.
    assign bus.ex_busy = busy_c & ~rst;

    // Shift-add multiplier datapath; only the low 32 product bits are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            product <= '0;
        end else if (mul_start_c) begin
            count   <= '0;
            mul_a   <= bus.rd1;
            mul_b   <= op_b;
            product <= '0;
        end else if (mul_step_c) begin
            if (mul_b[0]) begin
                product <= product + mul_a;
            end
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count + CNT_W'(1);
        end
    end

    // EX/MEM pipeline register: bubbles while the multiplier runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_out        <= '0;
            bus.mem_out       <= '0;
            bus.branch_target <= '0;
            bus.zero          <= 1'b0;
            bus.alu_result    <= '0;
            bus.rd2_out       <= '0;
            bus.write_reg     <= '0;
        end else begin
            bus.branch_target <= bus.npc + (bus.sign_ext << 2);
            bus.rd2_out       <= bus.rd2;
            bus.write_reg     <= reg_dst ? bus.rd : bus.rt;
            if (mul_finish_c) begin
                bus.wb_out     <= bus.wb_in;
                bus.mem_out    <= bus.mem_in;
                bus.alu_result <= product;
                bus.zero       <= (product == '0);
            end else if (mul_start_c || mul_step_c) begin
                bus.wb_out     <= '0;
                bus.mem_out    <= '0;
                bus.alu_result <= alu_c;
                bus.zero       <= (alu_c == '0);
            end else begin
                bus.wb_out     <= bus.wb_in;
                bus.mem_out    <= bus.mem_in;
                bus.alu_result <= alu_c;
                bus.zero       <= (alu_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table plus MULT/reset sequences.
module tb_ex_stage;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    ex_stage_if bus ();

    ex_stage #(.MUL_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ctl;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [31:0] e_bt;
        logic [4:0]  e_wr;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] mem,
                                input logic [3:0] ctl, input logic [31:0] npc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] e_alu,
                                input logic e_zero, input logic [31:0] e_bt,
                                input logic [4:0] e_wr);
        vec_t v;
        v.wb = wb; v.mem = mem; v.ctl = ctl; v.npc = npc; v.a = a; v.b = b;
        v.imm = imm; v.rt = rt; v.rd = rd; v.e_alu = e_alu; v.e_zero = e_zero;
        v.e_bt = e_bt; v.e_wr = e_wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wb_in    = v.wb;
        bus.mem_in   = v.mem;
        bus.ex_ctl   = v.ctl;
        bus.npc      = v.npc;
        bus.rd1      = v.a;
        bus.rd2      = v.b;
        bus.sign_ext = v.imm;
        bus.rt       = v.rt;
        bus.rd       = v.rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},  32'(bus.ex_busy), 32'd0);
        chk({tag, " wb"},    32'(bus.wb_out), 32'd0);
        chk({tag, " mem"},   32'(bus.mem_out), 32'd0);
        chk({tag, " bt"},    bus.branch_target, 32'd0);
        chk({tag, " zero"},  32'(bus.zero), 32'd0);
        chk({tag, " alu"},   bus.alu_result, 32'd0);
        chk({tag, " rd2"},   bus.rd2_out, 32'd0);
        chk({tag, " wreg"},  32'(bus.write_reg), 32'd0);
    endtask

    // Runs one MULT from its arrival cycle; caller has just driven it at posedge+1.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        vec_t v;
        int   busy_cnt;
        int   bubble_bad;
        v = mk(2'b10, 3'b010, 4'b1100, 32'h0000_0040, a, b, 32'h0000_0018, 5'd3, 5'd9,
               exp, (exp == 32'd0), 32'h0000_00A0, 5'd9);
        drive(v);
        #1;
        busy_cnt   = 0;
        bubble_bad = 0;
        while (bus.ex_busy && busy_cnt < 40) begin
            busy_cnt++;
            @(posedge clk);
            #1;
            if (bus.wb_out !== 2'b00 || bus.mem_out !== 3'b000) bubble_bad++;
        end
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, " bubbles"}, 32'(bubble_bad), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " alu"},  bus.alu_result, v.e_alu);
        chk({tag, " zero"}, 32'(bus.zero), 32'(v.e_zero));
        chk({tag, " wb"},   32'(bus.wb_out), 32'(v.wb));
        chk({tag, " mem"},  32'(bus.mem_out), 32'(v.mem));
        chk({tag, " wreg"}, 32'(bus.write_reg), 32'(v.e_wr));
        chk({tag, " bt"},   bus.branch_target, v.e_bt);
        chk({tag, " rd2"},  bus.rd2_out, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_total = 0;
        n_pass  = 0;

        //        wb     mem     ctl      npc           a             b             imm           rt  rd   alu           z  bt            wr
        vecs[0] = mk(2'b10, 3'b001, 4'b0001, 32'h0,       32'd5,        32'd0,        32'd7,        3, 0,  32'd12,       0, 32'h1C,       3);
        vecs[1] = mk(2'b01, 3'b000, 4'b1100, 32'h100,     32'hFFFFFFFF, 32'd1,        32'h20,       3, 5,  32'd0,        1, 32'h180,      5);
        vecs[2] = mk(2'b01, 3'b000, 4'b1100, 32'h100,     32'hFFFFFFFF, 32'd1,        32'h2A,       3, 5,  32'd1,        0, 32'h1A8,      5);
        vecs[3] = mk(2'b01, 3'b000, 4'b1100, 32'h0,       32'd9,        32'd9,        32'h22,       3, 7,  32'd0,        1, 32'h88,       7);
        vecs[4] = mk(2'b00, 3'b100, 4'b0010, 32'h100,     32'd4,        32'd4,        32'hFFFFFFFF, 3, 5,  32'd0,        1, 32'hFC,       3);
        vecs[5] = mk(2'b10, 3'b001, 4'b0001, 32'hFFFFFFFC, 32'd10,      32'd0,        32'd1,        3, 5,  32'd11,       0, 32'h0,        3);
        vecs[6] = mk(2'b01, 3'b000, 4'b1100, 32'h0,       32'hF0F0FFFF, 32'h0FF000FF, 32'h24,       3, 5,  32'h00F000FF, 0, 32'h90,       5);
        vecs[7] = mk(2'b01, 3'b000, 4'b1100, 32'h0,       32'hF0F0FFFF, 32'h0FF000FF, 32'h25,       3, 5,  32'hFFF0FFFF, 0, 32'h94,       5);
        vecs[8] = mk(2'b11, 3'b101, 4'b1100, 32'h0,       32'd6,        32'd7,        32'h3F,       3, 5,  32'd0,        1, 32'hFC,       5);
        vecs[9] = mk(2'b11, 3'b011, 4'b0110, 32'h4,       32'd6,        32'd7,        32'h0,        3, 5,  32'd0,        1, 32'h4,        3);

        // Reset with random inputs
        rst          = 1'b1;
        bus.wb_in    = 2'($urandom);
        bus.mem_in   = 3'($urandom);
        bus.ex_ctl   = 4'($urandom);
        bus.npc      = $urandom;
        bus.rd1      = $urandom;
        bus.rd2      = $urandom;
        bus.sign_ext = $urandom;
        bus.rt       = 5'($urandom);
        bus.rd       = 5'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Directed single-cycle vectors
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            drive(v);
            #1;
            chk($sformatf("v%0d busy", i), 32'(bus.ex_busy), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d alu", i),  bus.alu_result, v.e_alu);
            chk($sformatf("v%0d zero", i), 32'(bus.zero), 32'(v.e_zero));
            chk($sformatf("v%0d bt", i),   bus.branch_target, v.e_bt);
            chk($sformatf("v%0d wreg", i), 32'(bus.write_reg), 32'(v.e_wr));
            chk($sformatf("v%0d wb", i),   32'(bus.wb_out), 32'(v.wb));
            chk($sformatf("v%0d mem", i),  32'(bus.mem_out), 32'(v.mem));
            chk($sformatf("v%0d rd2", i),  bus.rd2_out, v.b);
        end

        // MULT, then a second MULT entering right after the first completes
        run_mult("mult1", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        run_mult("mult2", 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);

        // Reset while the multiplier sits at count 10
        v = mk(2'b10, 3'b010, 4'b1100, 32'h40, 32'd7, 32'd8, 32'h18, 3, 9, 0, 0, 0, 9);
        drive(v);
        repeat (11) @(posedge clk);
        #1;
        chk("mid-mult busy before reset", 32'(bus.ex_busy), 32'd1);
        rst = 1'b1;
        v = mk(2'b01, 3'b110, 4'b0001, 32'h8, 32'd100, 32'd0, 32'hFFFFFFFF, 4, 0,
               32'd99, 0, 32'h4, 4);
        drive(v);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("mid-mult reset");
        @(posedge clk);
        #1;
        chk("post-reset add alu",  bus.alu_result, v.e_alu);
        chk("post-reset add zero", 32'(bus.zero), 32'(v.e_zero));
        chk("post-reset add bt",   bus.branch_target, v.e_bt);
        chk("post-reset add wb",   32'(bus.wb_out), 32'(v.wb));
        chk("post-reset add mem",  32'(bus.mem_out), 32'(v.mem));
        chk("post-reset add wreg", 32'(bus.write_reg), 32'(v.e_wr));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

- Execute stage of the 5-stage pipeline; sits after the ID/EX pipeline register and consumes its fields: WB/MEM/EX control, NPC, register operands, sign-extended immediate, rt/rd.
- Computes the ALU result, zero flag, branch target and destination register, and registers them into the EX/MEM boundary.
- Supports a 32-cycle iterative shift-add MULT (low 32 bits). While MULT runs, asserts `ex_busy` to freeze upstream and issues bubbles downstream.

## Interface
Parameters:
- MUL_CYCLES, 32, iterations of the shift-add multiplier; counter width is clog2(MUL_CYCLES).

Ports (rst is synchronous, active-high; clock is clk):
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- wb_in  in  2  WB control from ID/EX
- mem_in  in  3  MEM control from ID/EX
- ex_ctl  in  4  EX control: [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- npc  in  32  PC+4 of the instruction
- rd1  in  32  register operand A
- rd2  in  32  register operand B
- sign_ext  in  32  sign-extended immediate; [5:0] is funct for R-type
- rt  in  5  instr[20:16]
- rd  in  5  instr[15:11]
- ex_busy  out  1  high while MULT occupies the stage; upstream must hold all inputs stable
- wb_out  out  2  registered WB control
- mem_out  out  3  registered MEM control
- branch_target  out  32  registered npc + (sign_ext << 2)
- zero  out  1  registered (alu_result == 0)
- alu_result  out  32  registered ALU/MULT result
- rd2_out  out  32  registered rd2 (store data)
- write_reg  out  5  registered RegDst ? rd : rt

## Operation
- Operand B: ALUSrc ? sign_ext : rd2.
- ALUOp 00: add. ALUOp 01: sub.
- ALUOp 10 (R-type), funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or.
  - 101010 slt: signed compare, result 1 or 0.
  - 011000 mult.
  - Any other funct: result 0, controls passed through unchanged.
- ALUOp 11: result 0.
- All arithmetic is 32-bit modulo 2^32; overflow is ignored.
- branch_target wraps at 2^32.
- MULT FSM, states IDLE, MUL, DONE:
  - IDLE: when a mult is decoded, `ex_busy`=1 combinationally. At the edge: capture multiplicand A, multiplier B and product=0; set count=0; go to MUL. EX/MEM loads a bubble: wb_out=0, mem_out=0, other fields as computed.
  - MUL: `ex_busy`=1. Each edge: if B[0], product += A; A <<= 1; B >>= 1; count++. After the iteration with count=MUL_CYCLES-1, go to DONE. EX/MEM loads a bubble each cycle.
  - DONE: `ex_busy`=0. At the edge, EX/MEM loads the held instruction's controls, write_reg, rd2_out and branch_target, with alu_result=product and zero=(product==0). Go to IDLE.
  - The held mult is not re-decoded in DONE.
- The low 32 bits of the product are identical for signed and unsigned operands.
- Non-mult instructions in IDLE: all EX/MEM outputs load the computed values every cycle. There is no enable.

## Timing
- Non-mult latency is 1 cycle: inputs in cycle N appear on the outputs after the edge ending cycle N.
- MULT: arrives in cycle C0; `ex_busy` is high for C0..C32 (33 cycles) and low in C33. The result is visible after the edge ending C33, 34 cycles after arrival.
- The instruction following a mult enters in C34.
- Reset values: all outputs 0, `ex_busy`=0, FSM in IDLE, count 0, product 0.
- Reset mid-MULT: at the next edge the FSM returns to IDLE, outputs are 0, and `ex_busy` drops. No partial result is emitted.
- Reset takes priority over every other event in the same cycle.
- `ex_busy` depends combinationally on the inputs in IDLE; it is registered-state-only in MUL and DONE.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0 and ex_busy=0. After release, add 5+7 (ALUOp 00, ALUSrc=1, sign_ext=7, rd1=5) -> alu_result=12, zero=0 one cycle later.
- R-type: rd1=0xFFFFFFFF, rd2=1, funct 100000 -> alu_result=0, zero=1. Same operands with slt -> alu_result=1. funct 100010 with rd1=rd2=9 -> zero=1.
- Branch/RegDst: npc=0x00000100, sign_ext=0xFFFFFFFF -> branch_target=0x000000FC. npc=0xFFFFFFFC, sign_ext=1 -> branch_target=0x00000000. RegDst=1, rd=5, rt=3 -> write_reg=5; RegDst=0 -> write_reg=3.
- MULT: rd1=0x00010003, rd2=0x00020005 -> ex_busy high exactly 33 cycles, bubbles downstream (wb_out=0, mem_out=0) throughout, then alu_result=0x000B000F with wb_out=wb_in. Also rd1=0xFFFFFFFF, rd2=2 -> 0xFFFFFFFE.
- Reset at MUL count=10 -> outputs 0 and ex_busy=0 next cycle. A following add executes normally with 1-cycle latency.
- Back-to-back: mult immediately followed by mult -> the second starts in C34 and its result is visible 34 cycles after it enters. Unknown funct 111111 -> alu_result=0 with controls passed through.
